data_loader_ctrl: RTL

Sequencing controller for the sample data loader. It walks the 8-bit sample index `cnt` over all 150 stored (x, y) pairs, repeating for a programmable number of passes (training epochs). It presents each sample to the downstream consumer through a valid/ready handshake. It sits between the top-level control (start/done) and the combinational sample ROM, whose `x`/`y` outputs follow `cnt` in the same cycle.

---
 rtl/data_loader_pkg.sv | 20 ++
 rtl/sample_counter.sv | 36 +++
 rtl/data_loader_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/data_loader_pkg.sv
// Shared constants and types for the sample data loader controller.
package data_loader_pkg;

    // Sample set geometry
    localparam int N_SAMPLES = 150;
    localparam int CNT_W     = 8;
    localparam int PASS_W    = 4;

    // Sample format: Q10.10 fixed point
    localparam int DATA_W    = 20;
    localparam int FRAC_W    = 10;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ldr_state_t;

endpackage

// File: rtl/sample_counter.sv
// Sample index register: clears to 0, increments up to a terminal count of
// N_SAMPLES-1 and flags that terminal count on o_wrap. It saturates at the
// terminal count; rolling back to 0 is done explicitly through i_clr.
module sample_counter #(
    parameter int N_SAMPLES = 150,
    parameter int CNT_W     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(N_SAMPLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == LP_LAST);
    assign o_cnt  = r_cnt;
    assign o_wrap = w_wrap;

    // Index register; clear has priority, increment never passes the terminal count
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_wrap) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/data_loader_ctrl.sv
// Sequencing controller for the sample data loader: walks the sample index
// over all stored samples for a programmable number of passes and offers each
// sample to the consumer through a valid/ready handshake.
module data_loader_ctrl #(
    parameter int N_SAMPLES = data_loader_pkg::N_SAMPLES,
    parameter int CNT_W     = data_loader_pkg::CNT_W,
    parameter int PASS_W    = data_loader_pkg::PASS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [PASS_W-1:0] passes,
    input  logic              ready,
    output logic [CNT_W-1:0]  cnt,
    output logic              valid,
    output logic              first,
    output logic              last,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              done
);

    import data_loader_pkg::*;

    ldr_state_t        r_state;
    ldr_state_t        w_next_state;

    logic [PASS_W-1:0] r_passes;
    logic [PASS_W-1:0] r_pass_idx;

    logic [CNT_W-1:0]  w_cnt;
    logic              w_cnt_wrap;
    logic              w_cnt_inc;
    logic              w_cnt_clr;
    logic              w_pass_inc;
    logic              w_pass_clr;
    logic              w_latch;
    logic              w_xfer;
    logic              w_last_pass;

    sample_counter #(
        .N_SAMPLES (N_SAMPLES),
        .CNT_W     (CNT_W)
    ) u_sample_counter (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_cnt_inc),
        .i_clr   (w_cnt_clr),
        .o_cnt   (w_cnt),
        .o_wrap  (w_cnt_wrap)
    );

    assign w_xfer      = (r_state == RUN) && ready;
    // Plain PASS_W-bit subtraction; only evaluated in RUN, where r_passes >= 1
    assign w_last_pass = (r_pass_idx == (r_passes - PASS_W'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latched pass count and current pass index
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_passes   <= '0;
            r_pass_idx <= '0;
        end else begin
            if (w_latch) begin
                r_passes <= passes;
            end
            if (w_pass_clr) begin
                r_pass_idx <= '0;
            end else if (w_pass_inc) begin
                r_pass_idx <= r_pass_idx + PASS_W'(1);
            end
        end
    end

    // Next-state and counter control
    always_comb begin
        w_next_state = r_state;
        w_cnt_inc    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_pass_inc   = 1'b0;
        w_pass_clr   = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_latch      = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_pass_clr   = 1'b1;
                    w_next_state = (passes == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Abort wins over a coincident transfer: the index is not advanced
                if (abort) begin
                    w_next_state = DONE;
                end else if (w_xfer) begin
                    if (!w_cnt_wrap) begin
                        w_cnt_inc = 1'b1;
                    end else if (!w_last_pass) begin
                        w_cnt_clr  = 1'b1;
                        w_pass_inc = 1'b1;
                    end else begin
                        w_next_state = DONE;
                    end
                end
            end
            DONE: begin
                w_next_state = IDLE;
                w_cnt_clr    = 1'b1;
                w_pass_clr   = 1'b1;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign cnt      = w_cnt;
    assign pass_idx = r_pass_idx;
    assign valid    = (r_state == RUN);
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign first    = valid && (w_cnt == '0);
    assign last     = valid && w_cnt_wrap;

endmodule
